ws2812_fade_sequencer: RTL and testbench

- Parametrised successor to the fixed 33-byte random-colour frame driver.
- Keeps a per-byte current and target colour store for NUM_LEDS LEDs of BYTES_PER_LED bytes each.
- Streams one frame per refresh into the ws2812 serializer byte handshake, then enforces a programmable inter-frame gap.
- On every frame, each byte steps FADE_STEP toward its target; a byte that has reached its target gets a new random target.

---
 rtl/ws2812_fade_sequencer.sv | 111 +++++++++++
 tb/tb_ws2812_fade_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ws2812_fade_sequencer.sv
// rtl/ws2812_fade_sequencer.sv - per-byte fading colour frame driver for a ws2812 serializer
// Optional quadratic gamma on ws_data when WS2812_GAMMA_EN is defined.
module ws2812_fade_sequencer #(
  parameter int NUM_LEDS      = 11,
  parameter int BYTES_PER_LED = 3,
  parameter int FADE_STEP     = 8,
  parameter int FRAME_GAP     = 1000
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] random,
  output logic       ws_trigger,
  output logic [7:0] ws_data,
  output logic       ws_more,
  input  logic       ws_request,
  output logic       frame_done,
  output logic       busy
);

  localparam int TOTAL = NUM_LEDS * BYTES_PER_LED;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int GAP_W = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(FRAME_GAP);
  localparam logic [8:0]       STEP     = 9'(FADE_STEP);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] TAIL   = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [GAP_W-1:0] gap_cnt;
  logic [7:0]       cur [TOTAL];
  logic [7:0]       tgt [TOTAL];

  logic [7:0] cur_sel;
  logic [7:0] tgt_sel;
  logic [8:0] c9, t9, diff, step, sum9;
  logic [7:0] cur_next;

  assign cur_sel = cur[idx];
  assign tgt_sel = tgt[idx];

  // 9-bit distance clamped to FADE_STEP, so cur lands exactly on tgt and never wraps
  always_comb begin
    c9   = {1'b0, cur_sel};
    t9   = {1'b0, tgt_sel};
    diff = (c9 < t9) ? (t9 - c9) : (c9 - t9);
    step = (diff < STEP) ? diff : STEP;
    sum9 = (c9 < t9) ? (c9 + step) : (c9 - step);
    cur_next = sum9[7:0];
  end

`ifdef WS2812_GAMMA_EN
  logic [15:0] sq;
  assign sq      = {8'd0, cur_sel} * {8'd0, cur_sel};
  assign ws_data = sq[15:8];
`else
  assign ws_data = cur_sel;
`endif

  assign ws_trigger = (state == STREAM);
  assign ws_more    = (state == STREAM);
  assign busy       = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < TOTAL; i++) begin
        cur[i] <= 8'd0;
        tgt[i] <= 8'd0;
      end
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= STREAM;
            idx   <= '0;
          end
        end
        STREAM: begin
          if (ws_request) begin
            if (cur_sel == tgt_sel) tgt[idx] <= random;
            else                    cur[idx] <= cur_next;
            if (idx == LAST_IDX) state <= TAIL;
            else                 idx   <= idx + 1'b1;
          end
        end
        TAIL: begin
          if (ws_request) begin
            state      <= GAP;
            gap_cnt    <= GAP_LOAD;
            frame_done <= 1'b1;
          end
        end
        default: begin
          if (gap_cnt == '0) state   <= IDLE;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_fade_sequencer.sv
// tb/tb_ws2812_fade_sequencer.sv - directed self-checking bench for ws2812_fade_sequencer
// Expected ws_data follows WS2812_GAMMA_EN when it is defined.
module tb_ws2812_fade_sequencer;

  logic       CLK = 1'b0;
  logic       rst_n, enable, ws_request;
  logic [7:0] random;
  logic       ws_trigger, ws_more, frame_done, busy;
  logic [7:0] ws_data;

  logic       g_rst_n, g_en, g_req;
  logic [7:0] g_random;
  logic       g_trig, g_more, g_done, g_busy;
  logic [7:0] g_data;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  ws2812_fade_sequencer #(
    .NUM_LEDS(2), .BYTES_PER_LED(3), .FADE_STEP(16), .FRAME_GAP(5)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .enable(enable), .random(random),
    .ws_trigger(ws_trigger), .ws_data(ws_data), .ws_more(ws_more),
    .ws_request(ws_request), .frame_done(frame_done), .busy(busy)
  );

  ws2812_fade_sequencer #(
    .NUM_LEDS(1), .BYTES_PER_LED(1), .FADE_STEP(255), .FRAME_GAP(0)
  ) dut_g (
    .CLK(CLK), .rst_n(g_rst_n), .enable(g_en), .random(g_random),
    .ws_trigger(g_trig), .ws_data(g_data), .ws_more(g_more),
    .ws_request(g_req), .frame_done(g_done), .busy(g_busy)
  );

  function automatic logic [7:0] gam(input logic [7:0] x);
`ifdef WS2812_GAMMA_EN
    logic [15:0] p;
    p = {8'd0, x} * {8'd0, x};
    return p[15:8];
`else
    return x;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for ws_trigger; optionally holds ws_request high meanwhile
  task automatic wait_stream(input bit inject, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      ws_request = inject;
      @(negedge CLK);
      n++;
      if (ws_trigger === 1'b1) seen = 1'b1;
    end
    ws_request = 1'b0;
    check("stream_start", 32'(seen), 32'd1);
  endtask

  task automatic byte_xfer(input logic [7:0] v);
    repeat (3) @(negedge CLK);
    check("ws_trigger", 32'(ws_trigger), 32'd1);
    check("ws_more", 32'(ws_more), 32'd1);
    check("ws_data", 32'(ws_data), 32'(gam(v)));
    ws_request = 1'b1;
    @(negedge CLK);
    ws_request = 1'b0;
  endtask

  task automatic tail_xfer();
    repeat (3) @(negedge CLK);
    check("tail_more", 32'(ws_more), 32'd0);
    check("tail_trigger", 32'(ws_trigger), 32'd0);
    check("tail_busy", 32'(busy), 32'd1);
    ws_request = 1'b1;
    @(negedge CLK);
    ws_request = 1'b0;
    check("frame_done_hi", 32'(frame_done), 32'd1);
    @(negedge CLK);
    check("frame_done_lo", 32'(frame_done), 32'd0);
  endtask

  task automatic full_frame(input bit inject, input logic [7:0] v, input bit chk_gap);
    int n;
    wait_stream(inject, n);
    if (chk_gap) check("gap_cycles", 32'(n + 1), 32'd7);
    for (int b = 0; b < 6; b++) byte_xfer(v);
    tail_xfer();
  endtask

  initial begin
    int n;
    bit seen;
    logic [7:0] gexp [3];

    rst_n = 1'b0; enable = 1'b0; ws_request = 1'b0; random = 8'h40;
    g_rst_n = 1'b0; g_en = 1'b0; g_req = 1'b0; g_random = 8'hFF;
    repeat (2) @(negedge CLK);
    check("rst_trigger", 32'(ws_trigger), 32'd0);
    check("rst_more", 32'(ws_more), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    rst_n = 1'b1; enable = 1'b1;
    full_frame(1'b0, 8'h00, 1'b0);
    full_frame(1'b0, 8'h00, 1'b1);
    full_frame(1'b1, 8'h10, 1'b1);
    full_frame(1'b0, 8'h20, 1'b0);
    full_frame(1'b0, 8'h30, 1'b0);
    random = 8'h20;
    full_frame(1'b0, 8'h40, 1'b0);
    full_frame(1'b0, 8'h40, 1'b0);
    full_frame(1'b0, 8'h30, 1'b0);

    random = 8'h40;
    wait_stream(1'b0, n);
    byte_xfer(8'h20);
    byte_xfer(8'h20);
    enable = 1'b0;
    for (int b = 0; b < 4; b++) byte_xfer(8'h20);
    tail_xfer();
    repeat (15) @(negedge CLK);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_trigger", 32'(ws_trigger), 32'd0);

    enable = 1'b1;
    wait_stream(1'b0, n);
    byte_xfer(8'h20);
    byte_xfer(8'h20);
    byte_xfer(8'h20);
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge CLK);
    check("rst_mid_more", 32'(ws_more), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    full_frame(1'b0, 8'h00, 1'b0);

    gexp[0] = 8'h00; gexp[1] = 8'h00; gexp[2] = gam(8'hFF);
    g_rst_n = 1'b1; g_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      seen = 1'b0;
      for (int w = 0; w < 20 && !seen; w++) begin
        @(negedge CLK);
        if (g_trig === 1'b1) seen = 1'b1;
      end
      check("g_start", 32'(seen), 32'd1);
      check("g_data", 32'(g_data), 32'(gexp[f]));
      g_req = 1'b1;
      @(negedge CLK);
      g_req = 1'b0;
      check("g_tail_more", 32'(g_more), 32'd0);
      g_req = 1'b1;
      @(negedge CLK);
      g_req = 1'b0;
      check("g_done", 32'(g_done), 32'd1);
      check("g_busy", 32'(g_busy), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
